// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer: latches the winning exception, saves EPC and
// cause, fetches the handler address byte from the vector table and loads the PC.
// An exception raised while already inside a handler is a double fault that halts
// the block until reset.
module exception_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic        rfe,
    input  logic [31:0] pc,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_sel,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        stall,
    output logic        halted
);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StFetch,
        StWait,
        StLoad,
        StReturn,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [1:0]  pend_q, pend_d;       // cause chosen in IDLE, committed in CAPTURE
    logic        in_handler_q, in_handler_d;
    logic [7:0]  byte_q, byte_d;       // handler address byte from the vector table
    logic        any_exc;

    assign any_exc = exc_opcode | exc_overflow | exc_divzero;
    assign epc     = epc_q;
    assign cause   = {30'b0, cause_q};

    // Next-state, register updates and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        pend_d       = pend_q;
        in_handler_d = in_handler_q;
        byte_d       = byte_q;
        mem_addr     = 32'd0;
        mem_sel      = 1'b0;
        pc_load      = 1'b0;
        pc_value     = 32'd0;
        stall        = 1'b1;
        halted       = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall = 1'b0;
                if (any_exc) begin
                    if (in_handler_q) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StCapture;
                        pend_d  = exc_opcode ? 2'd0 : (exc_overflow ? 2'd1 : 2'd2);
                    end
                end else if (rfe && in_handler_q) begin
                    state_d = StReturn;
                end
            end
            StCapture: begin
                epc_d        = pc - 32'd4;
                cause_d      = pend_q;
                in_handler_d = 1'b1;
                state_d      = StFetch;
            end
            StFetch: begin
                mem_sel  = 1'b1;
                mem_addr = 32'd253 + {30'b0, cause_q};
                state_d  = StWait;
            end
            StWait: begin
                mem_sel  = 1'b1;
                mem_addr = 32'd253 + {30'b0, cause_q};
                byte_d   = mem_data[31:24];
                state_d  = StLoad;
            end
            StLoad: begin
                pc_load  = 1'b1;
                pc_value = {24'b0, byte_q};
                state_d  = StIdle;
            end
            StReturn: begin
                pc_load      = 1'b1;
                pc_value     = epc_q;
                in_handler_d = 1'b0;
                state_d      = StIdle;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and architectural registers, synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            epc_q        <= 32'd0;
            cause_q      <= 2'd0;
            pend_q       <= 2'd0;
            in_handler_q <= 1'b0;
            byte_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            pend_q       <= pend_d;
            in_handler_q <= in_handler_d;
            byte_q       <= byte_d;
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model that schedules the
// expected per-cycle outputs of each accepted exception or return.
module tb_exception_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_divzero, rfe;
    logic [31:0] pc, mem_data;
    logic [31:0] mem_addr, pc_value, epc, cause;
    logic        mem_sel, pc_load, stall, halted;

    int n_tests = 0;
    int n_fail  = 0;

    exception_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_divzero  (exc_divzero),
        .rfe          (rfe),
        .pc           (pc),
        .mem_data     (mem_data),
        .mem_addr     (mem_addr),
        .mem_sel      (mem_sel),
        .pc_load      (pc_load),
        .pc_value     (pc_value),
        .epc          (epc),
        .cause        (cause),
        .stall        (stall),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic        mem_sel;
        logic [31:0] mem_addr;
        logic        pc_load;
        logic [31:0] pc_value;
        logic [31:0] epc;
        logic [31:0] cause;
        logic        halted;
    } obs_t;

    // Model state
    obs_t        exp_cur;
    obs_t        sched_q[$];
    logic        cur_idle;
    logic [31:0] m_epc, m_cause;
    logic        m_in_handler, m_halted;

    function automatic obs_t mk(input logic st, input logic sel, input logic [31:0] addr,
                                input logic ld, input logic [31:0] val,
                                input logic [31:0] e, input logic [31:0] c,
                                input logic h);
        obs_t o;
        o.stall = st; o.mem_sel = sel; o.mem_addr = addr; o.pc_load = ld;
        o.pc_value = val; o.epc = e; o.cause = c; o.halted = h;
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_all(input obs_t e);
        check_eq("stall", {31'b0, stall}, {31'b0, e.stall});
        check_eq("mem_sel", {31'b0, mem_sel}, {31'b0, e.mem_sel});
        check_eq("mem_addr", mem_addr, e.mem_addr);
        check_eq("pc_load", {31'b0, pc_load}, {31'b0, e.pc_load});
        check_eq("pc_value", pc_value, e.pc_value);
        check_eq("epc", epc, e.epc);
        check_eq("cause", cause, e.cause);
        check_eq("halted", {31'b0, halted}, {31'b0, e.halted});
    endtask

    // Work out what the next cycle must look like from this cycle's inputs
    task automatic model_advance(input logic eo, input logic ev, input logic ed,
                                 input logic rf, input logic rs,
                                 input logic [31:0] p, input logic [31:0] md);
        logic [31:0] c, new_epc;
        if (rs) begin
            sched_q.delete();
            m_epc = 0; m_cause = 0; m_in_handler = 0; m_halted = 0;
            exp_cur  = mk(0, 0, 0, 0, 0, 0, 0, 0);
            cur_idle = 1;
        end else if (!cur_idle) begin
            if (sched_q.size() > 0) begin
                exp_cur = sched_q.pop_front();
            end else if (m_halted) begin
                exp_cur = mk(1, 0, 0, 0, 0, m_epc, m_cause, 1);
            end else begin
                exp_cur  = mk(0, 0, 0, 0, 0, m_epc, m_cause, 0);
                cur_idle = 1;
            end
        end else if (eo || ev || ed) begin
            cur_idle = 0;
            if (m_in_handler) begin
                m_halted = 1;
                exp_cur  = mk(1, 0, 0, 0, 0, m_epc, m_cause, 1);
            end else begin
                c       = eo ? 32'd0 : (ev ? 32'd1 : 32'd2);
                new_epc = p - 32'd4;
                exp_cur = mk(1, 0, 0, 0, 0, m_epc, m_cause, 0);
                sched_q.push_back(mk(1, 1, 32'd253 + c, 0, 0, new_epc, c, 0));
                sched_q.push_back(mk(1, 1, 32'd253 + c, 0, 0, new_epc, c, 0));
                sched_q.push_back(mk(1, 0, 0, 1, md >> 24, new_epc, c, 0));
                m_epc = new_epc; m_cause = c; m_in_handler = 1;
            end
        end else if (rf && m_in_handler) begin
            cur_idle     = 0;
            exp_cur      = mk(1, 0, 0, 1, m_epc, m_epc, m_cause, 0);
            m_in_handler = 0;
        end else begin
            exp_cur = mk(0, 0, 0, 0, 0, m_epc, m_cause, 0);
        end
    endtask

    // One clock cycle: drive, check at negedge, advance the model, land at posedge+1
    task automatic step(input logic eo, input logic ev, input logic ed, input logic rf,
                        input logic rs, input logic [31:0] p, input logic [31:0] md);
        exc_opcode = eo; exc_overflow = ev; exc_divzero = ed; rfe = rf;
        reset = rs; pc = p; mem_data = md;
        @(negedge clock);
        check_all(exp_cur);
        model_advance(eo, ev, ed, rf, rs, p, md);
        @(posedge clock);
        #1;
    endtask

    logic [31:0] r_pc, r_md;
    logic        r_eo, r_ev, r_ed, r_rf, r_rs;

    initial begin
        reset = 1; exc_opcode = 0; exc_overflow = 0; exc_divzero = 0; rfe = 0;
        pc = 0; mem_data = 0;
        @(posedge clock); @(posedge clock); #1;
        sched_q.delete();
        m_epc = 0; m_cause = 0; m_in_handler = 0; m_halted = 0;
        exp_cur = mk(0, 0, 0, 0, 0, 0, 0, 0); cur_idle = 1;
        reset = 0;

        // Overflow entry from pc 0x40, handler byte 0x80
        step(0, 1, 0, 0, 0, 32'h40, 32'h8012_3456);
        check_eq("entry_stall", {31'b0, stall}, 32'd1);
        step(0, 0, 0, 0, 0, 32'h40, 32'h8012_3456);
        check_eq("fetch_addr_ovf", mem_addr, 32'd254);
        check_eq("fetch_sel", {31'b0, mem_sel}, 32'd1);
        step(0, 0, 0, 0, 0, 32'h40, 32'h8012_3456);
        step(0, 0, 0, 0, 0, 32'h40, 32'h8012_3456);
        check_eq("load_strobe", {31'b0, pc_load}, 32'd1);
        check_eq("load_value", pc_value, 32'h80);
        step(0, 0, 0, 0, 0, 32'h40, 32'h8012_3456);
        check_eq("epc_ovf", epc, 32'h3C);
        check_eq("cause_ovf", cause, 32'd1);
        check_eq("idle_stall", {31'b0, stall}, 32'd0);

        // Return, then a second return that must be ignored
        step(0, 0, 0, 1, 0, 32'h80, 32'h0);
        check_eq("rfe_strobe", {31'b0, pc_load}, 32'd1);
        check_eq("rfe_value", pc_value, 32'h3C);
        step(0, 0, 0, 0, 0, 32'h80, 32'h0);
        step(0, 0, 0, 1, 0, 32'h80, 32'h0);
        check_eq("rfe_ignored", {31'b0, pc_load}, 32'd0);
        check_eq("rfe_ignored_stall", {31'b0, stall}, 32'd0);

        // Opcode and divzero together: opcode wins
        step(1, 0, 1, 1, 0, 32'h100, 32'h1100_0000);
        step(0, 0, 0, 0, 0, 32'h100, 32'h1100_0000);
        check_eq("fetch_addr_opc", mem_addr, 32'd253);
        step(0, 0, 0, 0, 0, 32'h100, 32'h1100_0000);
        step(0, 0, 0, 0, 0, 32'h100, 32'h1100_0000);
        step(0, 0, 0, 0, 0, 32'h100, 32'h1100_0000);
        check_eq("cause_opc", cause, 32'd0);
        check_eq("epc_opc", epc, 32'hFC);

        // Double fault, halt is sticky until reset
        step(0, 0, 1, 0, 0, 32'h200, 32'h0);
        check_eq("halt_flag", {31'b0, halted}, 32'd1);
        check_eq("halt_stall", {31'b0, stall}, 32'd1);
        check_eq("halt_epc", epc, 32'hFC);
        check_eq("halt_cause", cause, 32'd0);
        step(0, 0, 0, 1, 0, 32'h200, 32'h0);
        step(1, 1, 1, 0, 0, 32'h200, 32'h0);
        check_eq("halt_sticky", {31'b0, halted}, 32'd1);
        step(0, 0, 0, 0, 1, 32'h200, 32'h0);
        check_eq("rst_halted", {31'b0, halted}, 32'd0);
        check_eq("rst_stall", {31'b0, stall}, 32'd0);
        check_eq("rst_epc", epc, 32'd0);
        check_eq("rst_cause", cause, 32'd0);

        // Reset while waiting for vector data
        step(0, 1, 0, 0, 0, 32'h200, 32'hAB00_0000);
        step(0, 0, 0, 0, 0, 32'h200, 32'hAB00_0000);
        step(0, 0, 0, 0, 0, 32'h200, 32'hAB00_0000);
        step(0, 0, 0, 0, 1, 32'h200, 32'hAB00_0000);
        check_eq("wait_rst_load", {31'b0, pc_load}, 32'd0);
        check_eq("wait_rst_epc", epc, 32'd0);
        check_eq("wait_rst_sel", {31'b0, mem_sel}, 32'd0);
        step(0, 0, 0, 0, 0, 32'h200, 32'hAB00_0000);

        // PC wrap-around
        step(1, 0, 0, 0, 0, 32'h0, 32'h4200_0000);
        step(0, 0, 0, 0, 0, 32'h0, 32'h4200_0000);
        check_eq("epc_wrap", epc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 32'h0, 32'h4200_0000);
        step(0, 0, 0, 0, 0, 32'h0, 32'h4200_0000);
        step(0, 0, 0, 0, 0, 32'h0, 32'h4200_0000);

        // Random traffic; pc/mem_data only change while the model sits in IDLE
        r_pc = 32'h40; r_md = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if (cur_idle) begin
                r_pc = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                r_md = $urandom;
            end
            r_eo = ($urandom_range(0, 11) == 0);
            r_ev = ($urandom_range(0, 11) == 0);
            r_ed = ($urandom_range(0, 11) == 0);
            r_rf = ($urandom_range(0, 2) == 0);
            r_rs = ($urandom_range(0, 49) == 0);
            step(r_eo, r_ev, r_ed, r_rf, r_rs, r_pc, r_md);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
